// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: request/idle controller for a downstream clock-gate cell.
//
// A system controller raises req_i when it wants the gated domain clocked.
// The block enables the clock, waits WAKE_CYC cycles for it to settle and
// then reports ready_o. Once nobody needs the clock (req_i and busy_i both
// low), it counts IDLE_CYC quiet cycles and then turns the clock off again.
//
// Optional build macro: CLK_GATE_CTRL_TEST_EN
//   When defined, an extra input test_en_i forces clk_en_o high for
//   scan/DFT. The FSM, ready_o and gate_off_o ignore test_en_i.
//
// Legal parameter range: CNT_W must be wide enough to hold
// max(WAKE_CYC, IDLE_CYC)-1 so the counter never wraps.

module clk_gate_ctrl #(
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 3,
  parameter int CNT_W    = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic busy_i,
`ifdef CLK_GATE_CTRL_TEST_EN
  input  logic test_en_i,
`endif
  output logic clk_en_o,
  output logic ready_o,
  output logic gate_off_o
);

  // The encoding is a Gray sequence around the normal loop
  // OFF -> WAKE -> ON -> COOL -> OFF, so clk_en_o (OR of both bits) and
  // ready_o (bit 1) each depend on a single toggling bit per transition.
  // The two shortcut transitions (OFF<->ON, used only when WAKE_CYC or
  // IDLE_CYC is zero) move both bits in the same direction, which keeps
  // the OR monotonic and therefore still free of glitches.
  typedef enum logic [1:0] {
    OFF  = 2'b00,
    WAKE = 2'b01,
    ON   = 2'b11,
    COOL = 2'b10
  } state_e;

  // Terminal counter values. A zero-cycle phase skips its state entirely,
  // so the terminal value for that phase is never used.
  localparam logic [CNT_W-1:0] WAKE_LAST =
    (WAKE_CYC > 0) ? CNT_W'(WAKE_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] IDLE_LAST =
    (IDLE_CYC > 0) ? CNT_W'(IDLE_CYC - 1) : '0;
  localparam bit WAKE_SKIP = (WAKE_CYC == 0);
  localparam bit IDLE_SKIP = (IDLE_CYC == 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              demand;

  // Anyone still needing the clock keeps it alive; this is the only
  // decision input once the clock is running.
  assign demand = req_i | busy_i;

  // State and counter registers; reset drops the clock immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic: wake countdown, idle countdown, restarts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      OFF: begin
        cnt_d = '0;
        if (req_i) begin
          state_d = WAKE_SKIP ? ON : WAKE;
        end
      end
      WAKE: begin
        // The wake always runs to completion, even if req_i drops.
        if (cnt_q == WAKE_LAST) begin
          state_d = ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ON: begin
        cnt_d = '0;
        if (!demand) begin
          state_d = IDLE_SKIP ? OFF : COOL;
        end
      end
      COOL: begin
        if (demand) begin
          // Any demand during the cool-down cancels it; the countdown
          // starts over from zero the next time demand disappears.
          state_d = ON;
          cnt_d   = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded purely from the state register (Moore outputs).
`ifdef CLK_GATE_CTRL_TEST_EN
  assign clk_en_o   = (state_q != OFF) | test_en_i;
`else
  assign clk_en_o   = (state_q != OFF);
`endif
  assign ready_o    = (state_q == ON) || (state_q == COOL);
  assign gate_off_o = (state_q == OFF);

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: self-checking bench for clk_gate_ctrl.
// Two instances: one with default parameters, one with WAKE_CYC=0 and
// IDLE_CYC=0 to exercise the direct OFF<->ON shortcuts.

module tb_clk_gate_ctrl;

  logic clk;
  logic rstN;
  logic req, busy;
  logic req0, busy0;
  logic clkEn, ready, gateOff;
  logic clkEn0, ready0, gateOff0;
`ifdef CLK_GATE_CTRL_TEST_EN
  logic testEn;
`endif

  int checks;
  int failures;

  clk_gate_ctrl #(.WAKE_CYC(2), .IDLE_CYC(3), .CNT_W(4)) dut (
    .clk_i     (clk),
    .rst_ni    (rstN),
    .req_i     (req),
    .busy_i    (busy),
`ifdef CLK_GATE_CTRL_TEST_EN
    .test_en_i (testEn),
`endif
    .clk_en_o  (clkEn),
    .ready_o   (ready),
    .gate_off_o(gateOff)
  );

  clk_gate_ctrl #(.WAKE_CYC(0), .IDLE_CYC(0), .CNT_W(1)) dut0 (
    .clk_i     (clk),
    .rst_ni    (rstN),
    .req_i     (req0),
    .busy_i    (busy0),
`ifdef CLK_GATE_CTRL_TEST_EN
    .test_en_i (testEn),
`endif
    .clk_en_o  (clkEn0),
    .ready_o   (ready0),
    .gate_off_o(gateOff0)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural reference model, index 0 = default instance, 1 = zero-cycle
  // instance. It tracks only "clock enabled", "ready", the edge at which the
  // clock was enabled and the last edge with demand, and derives the
  // latencies from edge arithmetic.
  int edgeN;
  bit mEn[2];
  bit mRdy[2];
  int mEnEdge[2];
  int mLastDem[2];

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mEn[i] = 1'b0;
      mRdy[i] = 1'b0;
      mEnEdge[i] = 0;
      mLastDem[i] = 0;
    end
  endtask

  task automatic modelStep(input int id, input logic rq, input logic bz,
                           input int wakeCyc, input int idleCyc);
    if (!mEn[id]) begin
      if (rq) begin
        mEn[id] = 1'b1;
        mEnEdge[id] = edgeN;
        if (wakeCyc == 0) begin
          mRdy[id] = 1'b1;
          mLastDem[id] = edgeN;
        end
      end
    end else if (!mRdy[id]) begin
      if (edgeN - mEnEdge[id] >= wakeCyc) begin
        mRdy[id] = 1'b1;
        mLastDem[id] = edgeN;
      end
    end else if (rq || bz) begin
      mLastDem[id] = edgeN;
    end else if (edgeN - mLastDem[id] >= idleCyc + 1) begin
      mEn[id] = 1'b0;
      mRdy[id] = 1'b0;
    end
  endtask

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: the model sees the inputs held across the edge, then
  // outputs settle and are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    edgeN++;
    modelStep(0, req, busy, 2, 3);
    modelStep(1, req0, busy0, 0, 0);
    #1;
  endtask

  task automatic applyStimulus(input logic rq, input logic bz);
    req = rq;
    busy = bz;
    tick();
  endtask

  task automatic doReset();
    rstN = 1'b0;
    req = 1'b0;
    busy = 1'b0;
    req0 = 1'b0;
    busy0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    rstN = 1'b1;
  endtask

  typedef struct {
    logic req;
    logic busy;
    logic en;
    logic rdy;
    logic off;
  } vec_t;

  vec_t vecs[20];

  initial begin
    checks = 0;
    failures = 0;
    edgeN = 0;
    rstN = 1'b1;
`ifdef CLK_GATE_CTRL_TEST_EN
    testEn = 1'b0;
`endif
    modelReset();

    // Wake / cool-down sequence for the default instance, starting in OFF
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    // Busy pulse in COOL at counter 1 restarts the idle countdown
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    // Busy alone never wakes the clock
    vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    doReset();
    checkOutput("reset clk_en", clkEn, 1'b0);
    checkOutput("reset ready", ready, 1'b0);
    checkOutput("reset gate_off", gateOff, 1'b1);
    checkOutput("reset0 clk_en", clkEn0, 1'b0);
    checkOutput("reset0 gate_off", gateOff0, 1'b1);

`ifdef CLK_GATE_CTRL_TEST_EN
    // Test enable forces the clock on without touching status outputs
    testEn = 1'b1;
    #1;
    checkOutput("test_en clk_en", clkEn, 1'b1);
    checkOutput("test_en ready", ready, 1'b0);
    checkOutput("test_en gate_off", gateOff, 1'b1);
    testEn = 1'b0;
    #1;
    checkOutput("test_en off clk_en", clkEn, 1'b0);
`endif

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].req, vecs[i].busy);
      checkOutput($sformatf("vec%0d clk_en", i), clkEn, vecs[i].en);
      checkOutput($sformatf("vec%0d ready", i), ready, vecs[i].rdy);
      checkOutput($sformatf("vec%0d gate_off", i), gateOff, vecs[i].off);
    end

    // Zero-cycle instance: one-cycle request gives a one-cycle enable
    req0 = 1'b1;
    tick();
    checkOutput("pulse0 clk_en high", clkEn0, 1'b1);
    checkOutput("pulse0 ready high", ready0, 1'b1);
    req0 = 1'b0;
    tick();
    checkOutput("pulse0 clk_en low", clkEn0, 1'b0);
    checkOutput("pulse0 ready low", ready0, 1'b0);
    checkOutput("pulse0 gate_off", gateOff0, 1'b1);

    // Asynchronous reset in the middle of the wake
    req = 1'b1;
    busy = 1'b0;
    tick();
    tick();
    checkOutput("midwake clk_en", clkEn, 1'b1);
    rstN = 1'b0;
    #2;
    checkOutput("async rst clk_en", clkEn, 1'b0);
    checkOutput("async rst ready", ready, 1'b0);
    checkOutput("async rst gate_off", gateOff, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("held rst clk_en", clkEn, 1'b0);
    modelReset();
    rstN = 1'b1;
    tick();
    checkOutput("rewake clk_en", clkEn, 1'b1);
    checkOutput("rewake ready e1", ready, 1'b0);
    tick();
    checkOutput("rewake ready e2", ready, 1'b0);
    tick();
    checkOutput("rewake ready e3", ready, 1'b1);

    // Randomized traffic on both instances against the reference model
    doReset();
    for (int c = 0; c < 400; c++) begin
      bit busyMode;
      busyMode = ((c / 25) % 2) == 0;
      req   = busyMode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      busy  = ($urandom_range(0, 5) == 0);
      req0  = ($urandom_range(0, 2) == 0);
      busy0 = ($urandom_range(0, 4) == 0);
      tick();
      checkOutput("rand clk_en", clkEn, mEn[0]);
      checkOutput("rand ready", ready, mRdy[0]);
      checkOutput("rand gate_off", gateOff, !mEn[0]);
      checkOutput("rand0 clk_en", clkEn0, mEn[1]);
      checkOutput("rand0 ready", ready0, mRdy[1]);
      checkOutput("rand0 gate_off", gateOff0, !mEn[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
